// File: rtl/fir_mac_scheduler_if.sv
// Sample, result and coefficient-write bundle for fir_mac_scheduler.
// The slave modport is the filter side; the master modport is the driver side.
interface fir_mac_scheduler_if #(
  parameter int DATA_WIDTH = 24,
  parameter int NUM_TAPS   = 16
);
  localparam int ADDR_WIDTH = $clog2(NUM_TAPS);

  logic                         i_en;
  logic                         i_valid;
  logic                         o_ready;
  logic signed [DATA_WIDTH-1:0] iv_din;
  logic                         o_valid;
  logic                         i_ready;
  logic signed [DATA_WIDTH-1:0] ov_dout;
  logic                         i_coef_we;
  logic        [ADDR_WIDTH-1:0] iv_coef_addr;
  logic signed [DATA_WIDTH-1:0] iv_coef_data;
  logic                         o_coef_err;

  modport slave (
    input  i_en, i_valid, iv_din, i_ready, i_coef_we, iv_coef_addr, iv_coef_data,
    output o_ready, o_valid, ov_dout, o_coef_err
  );

  modport master (
    output i_en, i_valid, iv_din, i_ready, i_coef_we, iv_coef_addr, iv_coef_data,
    input  o_ready, o_valid, ov_dout, o_coef_err
  );
endinterface

// File: rtl/fir_mac_scheduler.sv
// Time-multiplexed FIR: one shared multiplier, one tap per enabled cycle, IDLE -> MAC -> OUT.
// Define FIR_MAC_SCHEDULER_SAT_EN to saturate the output instead of two's-complement wrap.
module fir_mac_scheduler #(
  parameter int DATA_WIDTH = 24,
  parameter int NUM_TAPS   = 16
) (
  input logic                  i_clk,
  input logic                  i_rst_n,
  fir_mac_scheduler_if.slave   bus
);
  localparam int ADDR_WIDTH = $clog2(NUM_TAPS);
  localparam int ACC_WIDTH  = DATA_WIDTH + ADDR_WIDTH;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StMac  = 2'd1;
  localparam logic [1:0] StOut  = 2'd2;

  localparam logic [ADDR_WIDTH-1:0] KLast = ADDR_WIDTH'(NUM_TAPS - 1);

  logic [1:0]                   state_q, state_d;
  logic [ADDR_WIDTH-1:0]        k_q, k_d;
  logic [ADDR_WIDTH-1:0]        base_q, base_d;
  logic [ADDR_WIDTH-1:0]        wr_ptr_q, wr_ptr_d;
  logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic signed [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                         err_q, err_d;
  logic                         run_q;
  logic signed [DATA_WIDTH-1:0] smp_q  [NUM_TAPS];
  logic signed [DATA_WIDTH-1:0] coef_q [NUM_TAPS];

  logic                           ready;
  logic                           accept;
  logic                           coef_wr;
  logic [ADDR_WIDTH-1:0]          smp_idx;
  logic signed [2*DATA_WIDTH-1:0] prod;
  logic signed [DATA_WIDTH-1:0]   prod_trunc;
  logic signed [ACC_WIDTH-1:0]    acc_sum;
  logic signed [DATA_WIDTH-1:0]   result;
  logic                           unused_bits;

  // run_q keeps o_ready low until the first edge after reset release.
  assign ready   = run_q && (state_q == StIdle);
  assign accept  = bus.i_en && bus.i_valid && ready;
  assign coef_wr = bus.i_en && bus.i_coef_we && (state_q == StIdle);

  assign smp_idx    = base_q - k_q;
  assign prod       = coef_q[k_q] * smp_q[smp_idx];
  assign prod_trunc = prod[2*DATA_WIDTH-2:DATA_WIDTH-1];
  assign acc_sum    = acc_q + {{ADDR_WIDTH{prod_trunc[DATA_WIDTH-1]}}, prod_trunc};

`ifdef FIR_MAC_SCHEDULER_SAT_EN
  localparam logic signed [ACC_WIDTH-1:0] AccMax =
    {{(ADDR_WIDTH + 1){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] AccMin =
    {{(ADDR_WIDTH + 1){1'b1}}, {(DATA_WIDTH - 1){1'b0}}};

  always_comb begin
    result = acc_sum[DATA_WIDTH-1:0];
    if (acc_sum > AccMax) begin
      result = {1'b0, {(DATA_WIDTH - 1){1'b1}}};
    end else if (acc_sum < AccMin) begin
      result = {1'b1, {(DATA_WIDTH - 1){1'b0}}};
    end
  end

  assign unused_bits = ^{prod[2*DATA_WIDTH-1], prod[DATA_WIDTH-2:0]};
`else
  assign result      = acc_sum[DATA_WIDTH-1:0];
  assign unused_bits = ^{prod[2*DATA_WIDTH-1], prod[DATA_WIDTH-2:0],
                         acc_sum[ACC_WIDTH-1:DATA_WIDTH]};
`endif

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    base_d   = base_q;
    wr_ptr_d = wr_ptr_q;
    acc_d    = acc_q;
    dout_d   = dout_q;
    err_d    = bus.i_en && bus.i_coef_we && (state_q != StIdle);
    if (bus.i_en) begin
      case (state_q)
        StIdle: begin
          if (accept) begin
            state_d  = StMac;
            k_d      = '0;
            acc_d    = '0;
            base_d   = wr_ptr_q;
            wr_ptr_d = wr_ptr_q + 1'b1;
          end
        end
        StMac: begin
          acc_d = acc_sum;
          k_d   = k_q + 1'b1;
          if (k_q == KLast) begin
            dout_d  = result;
            state_d = StOut;
          end
        end
        StOut: begin
          if (bus.i_ready) begin
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= StIdle;
      k_q      <= '0;
      base_q   <= '0;
      wr_ptr_q <= '0;
      acc_q    <= '0;
      dout_q   <= '0;
      err_q    <= 1'b0;
      run_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      base_q   <= base_d;
      wr_ptr_q <= wr_ptr_d;
      acc_q    <= acc_d;
      dout_q   <= dout_d;
      err_q    <= err_d;
      run_q    <= 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NUM_TAPS; i++) begin
        smp_q[i]  <= '0;
        coef_q[i] <= '0;
      end
    end else begin
      if (accept) begin
        smp_q[wr_ptr_q] <= bus.iv_din;
      end
      if (coef_wr) begin
        coef_q[bus.iv_coef_addr] <= bus.iv_coef_data;
      end
    end
  end

  assign bus.o_ready    = ready;
  assign bus.o_valid    = (state_q == StOut);
  assign bus.ov_dout    = dout_q;
  assign bus.o_coef_err = err_q;
endmodule

// File: tb/tb_fir_mac_scheduler.sv
// Directed bench for fir_mac_scheduler: impulse, overflow, backpressure, coefficient
// write rules, mid-MAC reset and clock-enable gating, against hand-computed values.
module tb_fir_mac_scheduler;
  localparam int DW = 24;
  localparam int NT = 16;

`ifdef FIR_MAC_SCHEDULER_SAT_EN
  localparam logic [DW-1:0] OvfExp = 24'h7FFFFF;
`else
  localparam logic [DW-1:0] OvfExp = 24'hFFFFE0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fir_mac_scheduler_if #(.DATA_WIDTH(DW), .NUM_TAPS(NT)) bus ();

  fir_mac_scheduler #(.DATA_WIDTH(DW), .NUM_TAPS(NT)) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [DW-1:0] dout;
  int lat, lows;
  logic seen;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic load_coefs(input logic [DW-1:0] c);
    for (int i = 0; i < NT; i++) begin
      bus.i_coef_we    = 1'b1;
      bus.iv_coef_addr = 4'(i);
      bus.iv_coef_data = c;
      @(negedge clk);
    end
    bus.i_coef_we = 1'b0;
  endtask

  task automatic accept(input logic [DW-1:0] din, input logic we,
                        input logic [3:0] addr, input logic [DW-1:0] data);
    int t = 0;
    while (!bus.o_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!bus.o_ready) check("ready_timeout", 32'(bus.o_ready), 32'd1);
    bus.i_valid      = 1'b1;
    bus.iv_din       = din;
    bus.i_coef_we    = we;
    bus.iv_coef_addr = addr;
    bus.iv_coef_data = data;
    @(negedge clk);
    bus.i_valid   = 1'b0;
    bus.i_coef_we = 1'b0;
  endtask

  // Entered one negedge after the accepting edge; lat counts negedges from the accept setup.
  task automatic wait_out(input bit toggle, output int l, output int lw,
                          output logic [DW-1:0] d);
    l  = 1;
    lw = 0;
    while (!bus.o_valid && l < 200) begin
      if (toggle) begin
        bus.i_en = ~bus.i_en;
        if (!bus.i_en) lw++;
      end
      @(negedge clk);
      l++;
    end
    bus.i_en = 1'b1;
    if (!bus.o_valid) check("out_timeout", 32'(bus.o_valid), 32'd1);
    d = bus.ov_dout;
  endtask

  task automatic take();
    bus.i_ready = 1'b1;
    @(negedge clk);
    bus.i_ready = 1'b0;
  endtask

  task automatic send(input logic [DW-1:0] din, output logic [DW-1:0] d);
    int l, lw;
    accept(din, 1'b0, 4'd0, '0);
    wait_out(1'b0, l, lw, d);
    take();
  endtask

  initial begin
    bus.i_en = 1'b1;
    bus.i_valid = 1'b0;
    bus.iv_din = '0;
    bus.i_ready = 1'b0;
    bus.i_coef_we = 1'b0;
    bus.iv_coef_addr = '0;
    bus.iv_coef_data = '0;

    // Reset state
    @(negedge clk);
    check("rst_ready", 32'(bus.o_ready), 32'd0);
    check("rst_valid", 32'(bus.o_valid), 32'd0);
    check("rst_dout", 32'(bus.ov_dout), 32'd0);
    check("rst_err", 32'(bus.o_coef_err), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst", 32'(bus.o_ready), 32'd1);

    // Impulse response
    load_coefs(24'h200000);
    for (int n = 0; n < 18; n++) begin
      accept((n == 0) ? 24'h400000 : 24'h0, 1'b0, 4'd0, '0);
      wait_out(1'b0, lat, lows, dout);
      if (n == 0) check("latency", 32'(lat), 32'd17);
      check($sformatf("impulse%0d", n), 32'(dout), (n < 16) ? 32'h100000 : 32'h0);
      take();
      if (n == 0) check("valid_drop", 32'(bus.o_valid), 32'd0);
    end

    // Overflow
    do_reset();
    load_coefs(24'h7FFFFF);
    for (int n = 0; n < 16; n++) begin
      send(24'h7FFFFF, dout);
      if (n == 0) check("ovf_first", 32'(dout), 32'h7FFFFE);
      if (n == 15) check("ovf_last", 32'(dout), 32'(OvfExp));
    end

    // Backpressure: i_valid with a large sample must be ignored while OUT stalls
    do_reset();
    load_coefs(24'h200000);
    accept(24'h400000, 1'b0, 4'd0, '0);
    wait_out(1'b0, lat, lows, dout);
    check("bp_dout", 32'(dout), 32'h100000);
    for (int i = 0; i < 10; i++) begin
      bus.i_valid = 1'b1;
      bus.iv_din  = 24'h7FFFFF;
      @(negedge clk);
      check($sformatf("bp_valid%0d", i), 32'(bus.o_valid), 32'd1);
      check($sformatf("bp_hold%0d", i), 32'(bus.ov_dout), 32'h100000);
      check($sformatf("bp_ready%0d", i), 32'(bus.o_ready), 32'd0);
    end
    bus.i_valid = 1'b0;
    take();
    send(24'h0, dout);
    check("bp_next", 32'(dout), 32'h100000);

    // Coefficient write rules
    do_reset();
    bus.i_coef_we    = 1'b1;
    bus.iv_coef_addr = 4'd3;
    bus.iv_coef_data = 24'h200000;
    @(negedge clk);
    bus.i_coef_we = 1'b0;
    check("err_idle", 32'(bus.o_coef_err), 32'd0);
    accept(24'h400000, 1'b0, 4'd0, '0);
    bus.i_coef_we    = 1'b1;
    bus.iv_coef_addr = 4'd3;
    bus.iv_coef_data = 24'h7FFFFF;
    @(negedge clk);
    bus.i_coef_we = 1'b0;
    check("err_pulse", 32'(bus.o_coef_err), 32'd1);
    @(negedge clk);
    check("err_clear", 32'(bus.o_coef_err), 32'd0);
    wait_out(1'b0, lat, lows, dout);
    check("cw_n0", 32'(dout), 32'h0);
    take();
    send(24'h0, dout);
    send(24'h0, dout);
    send(24'h0, dout);
    check("coef3_kept", 32'(dout), 32'h100000);
    accept(24'h0, 1'b1, 4'd4, 24'h7FFFFF);
    check("err_same_cycle", 32'(bus.o_coef_err), 32'd0);
    wait_out(1'b0, lat, lows, dout);
    check("coef_same_cycle", 32'(dout), 32'h3FFFFF);
    take();

    // Reset during MAC aborts the sample and clears the buffer
    do_reset();
    load_coefs(24'h200000);
    send(24'h0, dout);
    check("abort_pre", 32'(dout), 32'h0);
    accept(24'h400000, 1'b0, 4'd0, '0);
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_valid", 32'(bus.o_valid), 32'd0);
    check("abort_ready", 32'(bus.o_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_ready_rel", 32'(bus.o_ready), 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      seen = seen | bus.o_valid;
    end
    check("abort_no_valid", 32'(seen), 32'd0);
    load_coefs(24'h200000);
    send(24'h0, dout);
    check("buffer_cleared", 32'(dout), 32'h0);

    // Clock enable toggled every cycle during MAC
    do_reset();
    load_coefs(24'h200000);
    accept(24'h400000, 1'b0, 4'd0, '0);
    wait_out(1'b1, lat, lows, dout);
    check("en_dout", 32'(dout), 32'h100000);
    check("en_lows", 32'(lows), 32'd16);
    check("en_latency", 32'(lat), 32'd33);
    take();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
